// File: rtl/logic_gate_unit_if.sv
// Operand, control and result bundle for the bitwise logic unit.
// Purely combinational wiring; no storage of its own.
// No backpressure: the source owns the valid/enable, the unit always accepts.
interface logic_gate_unit_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 ena;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           op_in;
    logic                 op_load;
    logic                 valid_in;
    logic                 cnt_clr;
    logic [WIDTH-1:0]     y;
    logic                 valid_out;
    logic [2:0]           op_cur;
    logic [CNT_WIDTH-1:0] toggles;

    modport master (
        output ena, a, b, op_in, op_load, valid_in, cnt_clr,
        input  y, valid_out, op_cur, toggles
    );

    modport slave (
        input  ena, a, b, op_in, op_load, valid_in, cnt_clr,
        output y, valid_out, op_cur, toggles
    );
endinterface

// File: rtl/logic_gate_unit.sv
// WIDTH-bit bitwise logic unit with loadable op, stallable output pipe and toggle counter.
// Latency: PIPE_STAGES cycles from sampled input to y/valid_out.
// No backpressure; ena=0 freezes every register (stall), inputs are accepted every enabled cycle.
module logic_gate_unit #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_gate_unit_if.slave   bus
);
    localparam int LAST = PIPE_STAGES - 1;
    localparam int PW   = $clog2(WIDTH + 1);
    localparam int SW   = CNT_WIDTH + PW + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [2:0]             op_q;
    logic [WIDTH-1:0]       res;
    logic [PIPE_STAGES-1:0] vld_q;
    logic [WIDTH-1:0]       dat_q   [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] nxt_vld;
    logic [WIDTH-1:0]       nxt_dat [PIPE_STAGES];
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_sat;
    logic [WIDTH-1:0]       diff;
    logic [PW-1:0]          pc;
    logic [SW-1:0]          sum;

    // Bitwise operation selected by the current (already registered) op.
    always_comb begin
        res = '0;
        case (op_q)
            3'd0:    res = ~bus.a;
            3'd1:    res = bus.a & bus.b;
            3'd2:    res = bus.a | bus.b;
            3'd3:    res = bus.a ^ bus.b;
            3'd4:    res = ~(bus.a & bus.b);
            3'd5:    res = ~(bus.a | bus.b);
            3'd6:    res = ~(bus.a ^ bus.b);
            default: res = bus.a;
        endcase
    end

    // Values each stage would capture on an enabled edge.
    always_comb begin
        nxt_vld = '0;
        for (int k = 0; k < PIPE_STAGES; k++) nxt_dat[k] = '0;
        nxt_vld[0] = bus.valid_in;
        nxt_dat[0] = res;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            nxt_vld[k] = vld_q[k-1];
            nxt_dat[k] = dat_q[k-1];
        end
    end

    // Toggle increment for a valid write into the output stage, saturating.
    always_comb begin
        diff = nxt_dat[LAST] ^ dat_q[LAST];
        pc   = '0;
        for (int i = 0; i < WIDTH; i++) pc = pc + PW'(diff[i]);
        sum     = SW'(cnt_q) + SW'(pc);
        cnt_sat = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
    end

    // State update: reset wins, otherwise everything advances only when enabled.
    // A stage's data register is only written by a valid entry, so y holds across bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= 3'd0;
            vld_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) dat_q[k] <= '0;
            cnt_q <= '0;
        end else if (bus.ena) begin
            if (bus.op_load) op_q <= bus.op_in;
            vld_q <= nxt_vld;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (nxt_vld[k]) dat_q[k] <= nxt_dat[k];
            end
            if (bus.cnt_clr)        cnt_q <= '0;
            else if (nxt_vld[LAST]) cnt_q <= cnt_sat;
        end
    end

    assign bus.y         = dat_q[LAST];
    assign bus.valid_out = vld_q[LAST];
    assign bus.op_cur    = op_q;
    assign bus.toggles   = cnt_q;
endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit across several parameter sets sharing one stimulus.
// Each scenario checks only the instance whose parameters it targets.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
module tb_logic_gate_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op_in;
    logic       op_load;
    logic       valid_in;
    logic       cnt_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_gate_unit_if #(.WIDTH(8), .CNT_WIDTH(8)) if1 ();
    logic_gate_unit_if #(.WIDTH(8), .CNT_WIDTH(8)) if2 ();
    logic_gate_unit_if #(.WIDTH(8), .CNT_WIDTH(8)) if3 ();
    logic_gate_unit_if #(.WIDTH(8), .CNT_WIDTH(4)) ifc ();

    assign if1.ena = ena;  assign if1.a = a;  assign if1.b = b;  assign if1.op_in = op_in;
    assign if1.op_load = op_load;  assign if1.valid_in = valid_in;  assign if1.cnt_clr = cnt_clr;
    assign if2.ena = ena;  assign if2.a = a;  assign if2.b = b;  assign if2.op_in = op_in;
    assign if2.op_load = op_load;  assign if2.valid_in = valid_in;  assign if2.cnt_clr = cnt_clr;
    assign if3.ena = ena;  assign if3.a = a;  assign if3.b = b;  assign if3.op_in = op_in;
    assign if3.op_load = op_load;  assign if3.valid_in = valid_in;  assign if3.cnt_clr = cnt_clr;
    assign ifc.ena = ena;  assign ifc.a = a;  assign ifc.b = b;  assign ifc.op_in = op_in;
    assign ifc.op_load = op_load;  assign ifc.valid_in = valid_in;  assign ifc.cnt_clr = cnt_clr;

    logic_gate_unit #(.WIDTH(8), .PIPE_STAGES(1), .CNT_WIDTH(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    logic_gate_unit #(.WIDTH(8), .PIPE_STAGES(2), .CNT_WIDTH(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    logic_gate_unit #(.WIDTH(8), .PIPE_STAGES(3), .CNT_WIDTH(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    logic_gate_unit #(.WIDTH(8), .PIPE_STAGES(1), .CNT_WIDTH(4)) uc (.clk(clk), .rst_n(rst_n), .bus(ifc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] sweep_exp [8];
    // PIPE_STAGES=3 stall scenario: inputs applied before each edge, outputs expected after it
    logic       p3_vin  [7];
    logic [7:0] p3_a    [7];
    logic       p3_ena  [7];
    logic       p3_vout [7];
    logic [7:0] p3_y    [7];

    initial begin
        sweep_exp = '{8'h33, 8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'hCC};
        p3_vin  = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        p3_a    = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
        p3_ena  = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        p3_vout = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
        p3_y    = '{8'h00, 8'h00, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hDD};

        rst_n = 1'b0; ena = 1'b0; a = '0; b = '0;
        op_in = '0; op_load = 1'b0; valid_in = 1'b0; cnt_clr = 1'b0;
        tick();
        tick();
        check("rst_y",       32'(if1.y), 32'h00);
        check("rst_vout",    32'(if1.valid_out), 32'h0);
        check("rst_op",      32'(if1.op_cur), 32'h0);
        check("rst_toggles", 32'(if1.toggles), 32'h0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Default NOT, single-stage latency, popcount(5A)=4
        a = 8'hA5; valid_in = 1'b1;
        tick();
        check("not_y",       32'(if1.y), 32'h5A);
        check("not_vout",    32'(if1.valid_out), 32'h1);
        check("not_toggles", 32'(if1.toggles), 32'h4);

        // Op load takes effect one edge after the load
        op_in = 3'd3; op_load = 1'b1; a = 8'hF0; b = 8'h0F;
        tick();
        check("load_old_op", 32'(if1.y), 32'h0F);
        check("load_op_cur", 32'(if1.op_cur), 32'h3);
        op_load = 1'b0;
        tick();
        check("load_new_op", 32'(if1.y), 32'hFF);

        // Sweep all ops; the load cycle is a bubble and y must hold
        for (int i = 0; i < 8; i++) begin
            op_in = 3'(i); op_load = 1'b1; valid_in = 1'b0;
            tick();
            check("bubble_vout", 32'(if1.valid_out), 32'h0);
            check("bubble_y",    32'(if1.y), (i == 0) ? 32'hFF : 32'(sweep_exp[i-1]));
            op_load = 1'b0; a = 8'hCC; b = 8'hAA; valid_in = 1'b1;
            tick();
            check($sformatf("sweep_op%0d", i), 32'(if1.y), 32'(sweep_exp[i]));
        end

        // Three-stage pipe with a two-cycle stall mid-flight (op back to NOT)
        valid_in = 1'b0;
        do_reset();
        for (int s = 0; s < 7; s++) begin
            valid_in = p3_vin[s]; a = p3_a[s]; ena = p3_ena[s];
            tick();
            check($sformatf("p3_vout_%0d", s), 32'(if3.valid_out), 32'(p3_vout[s]));
            check($sformatf("p3_y_%0d", s),    32'(if3.y), 32'(p3_y[s]));
        end
        ena = 1'b1; valid_in = 1'b0;

        // Four-bit saturating toggle counter
        do_reset();
        a = 8'h00; valid_in = 1'b1;
        tick();
        check("cnt_8", 32'(ifc.toggles), 32'h8);
        a = 8'hFF;
        tick();
        check("cnt_sat", 32'(ifc.toggles), 32'hF);
        a = 8'h00;
        tick();
        check("cnt_hold_sat", 32'(ifc.toggles), 32'hF);
        a = 8'hFF; cnt_clr = 1'b1;
        tick();
        check("cnt_clr_wins", 32'(ifc.toggles), 32'h0);
        check("cnt_clr_y",    32'(ifc.y), 32'h00);
        cnt_clr = 1'b0; a = 8'h00;
        tick();
        check("cnt_after_clr", 32'(ifc.toggles), 32'h8);
        ena = 1'b0; cnt_clr = 1'b1; a = 8'hFF;
        tick();
        check("cnt_clr_stalled", 32'(ifc.toggles), 32'h8);
        check("stall_y",         32'(ifc.y), 32'hFF);
        ena = 1'b1; cnt_clr = 1'b0; valid_in = 1'b0;

        // Reset with two results in flight in a two-stage pipe
        do_reset();
        op_in = 3'd5; op_load = 1'b1; a = 8'h01; valid_in = 1'b1;
        tick();
        op_load = 1'b0; a = 8'h02;
        tick();
        check("p2_pre_vout", 32'(if2.valid_out), 32'h1);
        check("p2_pre_y",    32'(if2.y), 32'hFE);
        check("p2_pre_op",   32'(if2.op_cur), 32'h5);
        rst_n = 1'b0; ena = 1'b0;
        tick();
        rst_n = 1'b1; ena = 1'b1; valid_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("flush_vout", 32'(if2.valid_out), 32'h0);
            check("flush_y",    32'(if2.y), 32'h00);
            check("flush_op",   32'(if2.op_cur), 32'h0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
